// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Serial pattern detector. Words of DW bits are accepted through a valid/ready
// handshake and scanned one bit per clock, MSB first. The most recent PLEN
// scanned bits are compared against 'pat'. A match produces a one-cycle
// registered pulse on Z. The scan history survives word boundaries, so a pattern
// that spans two consecutive words is also detected. Matching can either
// overlap or not overlap.
//
// Optional feature: define SEQ_DET_COUNT_EN to build the 16-bit saturating
// match counter. When the macro is not defined, match_cnt is tied to zero and
// no counter logic is built.
//
// Ports
//   clk        in   clock, rising-edge active
//   reset      in   asynchronous reset, active low
//   clear      in   synchronous flush of scan state and counter
//   in_valid   in   in_data holds a word
//   in_ready   out  a word is accepted this cycle (IDLE, or on the last scan bit)
//   in_data    in   DW-bit word, scanned MSB first
//   pat        in   PLEN-bit target pattern, pat[PLEN-1] is the oldest bit
//   overlap    in   1 = overlapping detection, 0 = non-overlapping
//   Z          out  registered one-cycle match pulse
//   busy       out  FSM is in SCAN
//   bit_idx    out  position of the next bit to scan
//   match_cnt  out  matches since reset or clear (saturating)
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int DW   = 8,
    parameter int PLEN = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_data,
    input  logic [PLEN-1:0]         pat,
    input  logic                    overlap,
    output logic                    Z,
    output logic                    busy,
    output logic [$clog2(DW)-1:0]   bit_idx,
    output logic [15:0]             match_cnt
);

    localparam int BW = $clog2(DW);
    localparam int FW = $clog2(PLEN + 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DW - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PLEN);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   word_q,  word_d;
    logic [BW-1:0]   idx_q,   idx_d;
    logic [PLEN-1:0] hist_q,  hist_d;
    logic [FW-1:0]   fill_q,  fill_d;
    logic            z_q,     z_d;

    logic            hs_s;
    logic            scan_bit_s;
    logic [PLEN-1:0] hist_shift_s;
    logic [FW-1:0]   fill_inc_s;
    logic            match_s;

    // A word can be taken whenever no scan bits remain beyond the current one.
    assign in_ready = (state_q == IDLE) || (idx_q == '0);
    assign busy     = (state_q == SCAN);
    assign bit_idx  = idx_q;
    assign Z        = z_q;

    // Next-state, scan datapath and match detection.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        idx_d        = idx_q;
        hist_d       = hist_q;
        fill_d       = fill_q;
        z_d          = 1'b0;
        match_s      = 1'b0;
        hs_s         = in_valid && in_ready;
        scan_bit_s   = word_q[idx_q];
        hist_shift_s = {hist_q[PLEN-2:0], scan_bit_s};
        fill_inc_s   = (fill_q == FILL_FULL) ? FILL_FULL : (fill_q + FW'(1));

        if (clear) begin
            // Flush wins over any handshake or scan in the same cycle.
            state_d = IDLE;
            word_d  = '0;
            idx_d   = '0;
            hist_d  = '0;
            fill_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs_s) begin
                        word_d  = in_data;
                        idx_d   = IDX_LAST;
                        state_d = SCAN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SCAN: begin
                    // pat and overlap are used live, so a change applies to
                    // the very next scanned bit.
                    match_s = (fill_inc_s == FILL_FULL) && (hist_shift_s == pat);
                    hist_d  = hist_shift_s;
                    z_d     = match_s;
                    if (match_s && !overlap) begin
                        fill_d = '0;
                    end else begin
                        fill_d = fill_inc_s;
                    end
                    if (idx_q != '0) begin
                        idx_d = idx_q - BW'(1);
                    end else if (hs_s) begin
                        // Reload on the last bit for gap-free streaming.
                        word_d  = in_data;
                        idx_d   = IDX_LAST;
                        state_d = SCAN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            z_q     <= z_d;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating match counter, flushed by clear.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 16'h0000;
        end else if (match_s && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'h0001;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Match counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Self-checking bench for seq_detector_param (DW=8, PLEN=4). The reference
// model holds the accepted-but-unscanned bits as a queue and the bits seen
// since the last non-overlapping match as a second queue; outputs are derived
// from queue sizes and the integer value of the last PLEN bits.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

    localparam int DW   = 8;
    localparam int PLEN = 4;
`ifdef SEQ_DET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            clear;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [PLEN-1:0] pat;
    logic            overlap;
    logic            Z;
    logic            busy;
    logic [2:0]      bit_idx;
    logic [15:0]     match_cnt;

    logic [21:0]     act_vec;
    assign act_vec = {Z, busy, in_ready, bit_idx, match_cnt};

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_pend[$];
    bit m_seen[$];
    int m_cnt = 0;
    bit m_z   = 1'b0;

    seq_detector_param #(.DW(DW), .PLEN(PLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .pat       (pat),
        .overlap   (overlap),
        .Z         (Z),
        .busy      (busy),
        .bit_idx   (bit_idx),
        .match_cnt (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_ready();
        return m_pend.size() <= 1;
    endfunction

    function automatic logic [21:0] exp_vec();
        logic [2:0]  bi;
        logic [15:0] c;
        bi = (m_pend.size() == 0) ? 3'd0 : 3'(m_pend.size() - 1);
        c  = CNT_EN ? 16'(m_cnt) : 16'h0000;
        return {m_z, (m_pend.size() > 0), m_ready(), bi, c};
    endfunction

    task automatic m_reset();
        m_pend.delete();
        m_seen.delete();
        m_cnt = 0;
        m_z   = 1'b0;
    endtask

    // Advance the model by one edge using the current inputs, then clock.
    task automatic tick();
        bit nz;
        bit hs;
        int v;
        hs = in_valid && m_ready();
        nz = 1'b0;
        if (clear) begin
            m_pend.delete();
            m_seen.delete();
            m_cnt = 0;
        end else begin
            if (m_pend.size() > 0) begin
                m_seen.push_back(m_pend.pop_front());
                if (m_seen.size() > PLEN) void'(m_seen.pop_front());
                if (m_seen.size() == PLEN) begin
                    v = 0;
                    foreach (m_seen[i]) v = v * 2 + int'(m_seen[i]);
                    if (v == int'(pat)) begin
                        nz = 1'b1;
                        if (m_cnt < 65535) m_cnt++;
                        if (!overlap) m_seen.delete();
                    end
                end
            end
            if (hs) begin
                for (int i = DW - 1; i >= 0; i--) m_pend.push_back(in_data[i]);
            end
        end
        m_z = nz;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        checks++;
        if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL clear_state: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0; clear = 1'b0; in_data = 8'h00;
        pat = 4'b1001; overlap = 1'b1; reset = 1'b0;
        #3;
        checks++;
        if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", act_vec, exp_vec());
        end
        @(posedge clk); #1;
        checks++;
        if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_held: got %h expected %h", act_vec, exp_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle: got %h expected %h", act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_single_word(input bit ov, input logic [8:0] exp_z,
                                    input logic [15:0] exp_cnt);
        logic [8:0] zseq;
        int busy_n;
        int rdy_busy_n;
        do_clear();
        pat = 4'b1001; overlap = ov;
        zseq = '0; busy_n = 0; rdy_busy_n = 0;
        for (int c = 0; c < 9; c++) begin
            in_valid = (c == 0);
            in_data  = 8'b10010010;
            tick();
            zseq = {zseq[7:0], Z};
            if (busy) busy_n++;
            if (busy && in_ready) rdy_busy_n++;
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL word_ov%0d cyc%0d: got %h expected %h", ov, c, act_vec, exp_vec());
            end
        end
        in_valid = 1'b0;
        checks++;
        if (zseq !== exp_z) begin
            errors++;
            $display("FAIL z_pulses_ov%0d: got %b expected %b", ov, zseq, exp_z);
        end
        checks++;
        if (match_cnt !== (CNT_EN ? exp_cnt : 16'h0000)) begin
            errors++;
            $display("FAIL cnt_ov%0d: got %h expected %h", ov, match_cnt, exp_cnt);
        end
        checks++;
        if (busy_n !== 8 || rdy_busy_n !== 1) begin
            errors++;
            $display("FAIL busy_ready_ov%0d: got busy=%0d ready=%0d expected 8 1", ov, busy_n, rdy_busy_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        bit hs;
        int busy_n;
        int z_n;
        int first_z;
        do_clear();
        pat = 4'b1001; overlap = 1'b1;
        q = '{8'b00000010, 8'b01000000};
        busy_n = 0; z_n = 0; first_z = -1;
        for (int c = 0; c < 40 && (q.size() > 0 || m_pend.size() > 0); c++) begin
            in_valid = (q.size() > 0);
            in_data  = (q.size() > 0) ? q[0] : 8'h00;
            hs = in_valid && m_ready();
            tick();
            if (hs) void'(q.pop_front());
            if (busy) busy_n++;
            if (Z) begin
                z_n++;
                if (first_z < 0) first_z = c;
            end
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL b2b cyc%0d: got %h expected %h", c, act_vec, exp_vec());
            end
        end
        in_valid = 1'b0;
        checks++;
        if (busy_n !== 16 || z_n !== 1 || first_z !== 10) begin
            errors++;
            $display("FAIL b2b_summary: got busy=%0d z=%0d at=%0d expected 16 1 10", busy_n, z_n, first_z);
        end
        checks++;
        if (match_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL b2b_cnt: got %h expected 1", match_cnt);
        end
    endtask

    task automatic test_reset_mid_word();
        pat = 4'b1001; overlap = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = (c == 0);
            in_data  = 8'b10011001;
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL rst_mid pre%0d: got %h expected %h", c, act_vec, exp_vec());
            end
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        checks++;
        if (act_vec !== 22'h080000) begin
            errors++;
            $display("FAIL rst_mid_async: got %h expected %h", act_vec, 22'h080000);
        end
        @(posedge clk); #1;
        checks++;
        if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL rst_mid_held: got %h expected %h", act_vec, exp_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec() || Z !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid_after%0d: got %h expected %h", c, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_clear_priority();
        logic [7:0] q[$];
        bit hs;
        do_clear();
        pat = 4'b1001; overlap = 1'b1;
        q = '{8'b10011001, 8'b10011001, 8'b10010000};
        for (int c = 0; c < 60 && (q.size() > 0 || m_pend.size() > 0); c++) begin
            in_valid = (q.size() > 0);
            in_data  = (q.size() > 0) ? q[0] : 8'h00;
            hs = in_valid && m_ready();
            tick();
            if (hs) void'(q.pop_front());
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL clr_pre cyc%0d: got %h expected %h", c, act_vec, exp_vec());
            end
        end
        checks++;
        if (match_cnt !== (CNT_EN ? 16'd5 : 16'd0) || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_preload: got cnt=%h busy=%b expected 5 0", match_cnt, busy);
        end
        clear = 1'b1; in_valid = 1'b1; in_data = 8'b10011001;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || match_cnt !== 16'h0000 || act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL clr_with_valid: got %h expected %h", act_vec, exp_vec());
        end
        tick();
        checks++;
        if (busy !== 1'b0 || act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL clr_next: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_saturation();
        logic [7:0] q[$];
        bit hs;
        int z_n;
        do_clear();
        pat = 4'b1111; overlap = 1'b1;
        for (int i = 0; i < 8192; i++) q.push_back(8'hFF);
        q.push_back(8'h80);
        for (int c = 0; c < 70000 && (q.size() > 0 || m_pend.size() > 0); c++) begin
            in_valid = (q.size() > 0);
            in_data  = (q.size() > 0) ? q[0] : 8'h00;
            hs = in_valid && m_ready();
            tick();
            if (hs) void'(q.pop_front());
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL sat_fill cyc%0d: got %h expected %h", c, act_vec, exp_vec());
            end
        end
        in_valid = 1'b0;
        checks++;
        if (q.size() > 0 || m_pend.size() > 0) begin
            errors++;
            $display("FAIL sat_timeout: got %0d words left expected 0", q.size());
        end
        checks++;
        if (match_cnt !== (CNT_EN ? 16'hFFFE : 16'h0000)) begin
            errors++;
            $display("FAIL sat_preload: got %h expected FFFE", match_cnt);
        end
        pat = 4'b1001;
        z_n = 0;
        for (int c = 0; c < 9; c++) begin
            in_valid = (c == 0);
            in_data  = 8'b10011001;
            tick();
            if (Z) z_n++;
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL sat_word cyc%0d: got %h expected %h", c, act_vec, exp_vec());
            end
        end
        in_valid = 1'b0;
        checks++;
        if (z_n !== 2 || match_cnt !== (CNT_EN ? 16'hFFFF : 16'h0000)) begin
            errors++;
            $display("FAIL sat_final: got z=%0d cnt=%h expected 2 FFFF", z_n, match_cnt);
        end
    endtask

    task automatic test_random();
        do_clear();
        for (int c = 0; c < 4000; c++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            in_data  = 8'($urandom);
            if ($urandom_range(0, 99) < 5) pat = 4'($urandom);
            if ($urandom_range(0, 99) < 5) overlap = 1'($urandom);
            clear = ($urandom_range(0, 99) < 2);
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d: got %h expected %h", c, act_vec, exp_vec());
            end
        end
        clear = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word(1'b1, 9'b000010010, 16'd2);
        test_single_word(1'b0, 9'b000010000, 16'd1);
        test_back_to_back();
        test_reset_mid_word();
        test_clear_priority();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
